// File: rtl/seg_frame_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and rebuilds 4-digit frames with per-digit indicators.
// Define SEGDEC_ERRCNT_EN to enable the saturating invalid-pattern counter on err_count.
module seg_frame_decoder #(
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  ind,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stale,
    output logic [7:0]  err_count
);

    localparam int          CW          = $clog2(STABLE_CYC + 1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      an_q, an_prev_q;
    logic [7:0]      seg_q, seg_prev_q;
    logic [15:0]     slot_code_q, slot_code_d;
    logic [3:0]      slot_ind_q, slot_ind_d;
    logic [3:0]      slot_err_q, slot_err_d;
    logic [3:0]      seen_q, seen_d;
    logic [15:0]     digits_q, digits_d;
    logic [3:0]      ind_q, ind_d;
    logic            frame_valid_q, frame_valid_d;
    logic            frame_err_q, frame_err_d;
    logic [15:0]     to_q, to_d;

    logic            onehot;
    logic [1:0]      idx;
    logic            changed;
    logic            settle_done;
    logic            slot_we;
    logic            publish;
    logic [3:0]      slot_hit;
    logic [3:0]      dec_code;
    logic            dec_err;

    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        case (p)
            7'b0000001: return {1'b0, 4'h0};
            7'b1001111: return {1'b0, 4'h1};
            7'b0010010: return {1'b0, 4'h2};
            7'b0000110: return {1'b0, 4'h3};
            7'b1001100: return {1'b0, 4'h4};
            7'b0100100: return {1'b0, 4'h5};
            7'b0100000: return {1'b0, 4'h6};
            7'b0001111: return {1'b0, 4'h7};
            7'b0000000: return {1'b0, 4'h8};
            7'b0000100: return {1'b0, 4'h9};
            7'b1111110: return {1'b0, 4'hF};
            7'b1111111: return {1'b0, 4'hA};
            default:    return {1'b1, 4'hE};
        endcase
    endfunction

    always_comb begin
        onehot = 1'b1;
        idx    = 2'd0;
        case (an_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: onehot = 1'b0;
        endcase
    end

    assign changed            = {an_q, seg_q} != {an_prev_q, seg_prev_q};
    assign settle_done        = !changed && ((int'(count_q) + 1) >= STABLE_CYC);
    assign {dec_err, dec_code} = decode_seg(seg_q[6:0]);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (onehot) begin
                    state_d = SETTLE;
                    count_d = CW'(1);
                end
            end
            SETTLE: begin
                if (changed) begin
                    state_d = onehot ? SETTLE : IDLE;
                    count_d = CW'(1);
                end else if (settle_done) begin
                    state_d = LOCKED;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            LOCKED: begin
                if (changed) begin
                    state_d = onehot ? SETTLE : IDLE;
                    count_d = CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        slot_we = 1'b0;
        if (state_q == SETTLE && settle_done) slot_we = 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_hit[gi]            = slot_we && (idx == 2'(gi));
            assign slot_code_d[gi*4 +: 4]  = slot_hit[gi] ? dec_code : slot_code_q[gi*4 +: 4];
            assign slot_ind_d[gi]          = slot_hit[gi] ? ~seg_q[7] : slot_ind_q[gi];
            assign slot_err_d[gi]          = slot_hit[gi] ? dec_err : slot_err_q[gi];
        end
    endgenerate

    assign publish = (seen_q == 4'b1111);

    // A slot written in the publish cycle survives the clear and starts the next frame.
    always_comb begin
        seen_d        = publish ? 4'b0000 : seen_q;
        seen_d        = seen_d | slot_hit;
        digits_d      = publish ? slot_code_q : digits_q;
        ind_d         = publish ? slot_ind_q : ind_q;
        frame_err_d   = publish ? (|slot_err_q) : frame_err_q;
        frame_valid_d = publish;
        if (publish)
            to_d = 16'd0;
        else if (to_q == TIMEOUT_VAL)
            to_d = to_q;
        else
            to_d = to_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q          <= 4'hF;
            seg_q         <= 8'hFF;
            an_prev_q     <= 4'hF;
            seg_prev_q    <= 8'hFF;
            slot_code_q   <= '0;
            slot_ind_q    <= '0;
            slot_err_q    <= '0;
            seen_q        <= '0;
            digits_q      <= '0;
            ind_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            to_q          <= '0;
        end else begin
            an_q          <= an;
            seg_q         <= seg;
            an_prev_q     <= an_q;
            seg_prev_q    <= seg_q;
            slot_code_q   <= slot_code_d;
            slot_ind_q    <= slot_ind_d;
            slot_err_q    <= slot_err_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            ind_q         <= ind_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            to_q          <= to_d;
        end
    end

`ifdef SEGDEC_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (slot_we && dec_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 8'h00;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

    assign digits      = digits_q;
    assign ind         = ind_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign stale       = (to_q == TIMEOUT_VAL);

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Bench for seg_frame_decoder: table-driven frames plus hand-written corner sequences, scoreboard-checked.
module tb_seg_frame_decoder;

    localparam int STABLE_CYC = 4;
    localparam int TIMEOUT    = 100;
`ifdef SEGDEC_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg = 8'hFF;
    logic [3:0]  an = 4'hF;
    logic [15:0] digits;
    logic [3:0]  ind;
    logic        frame_valid;
    logic        frame_err;
    logic        stale;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    seg_frame_decoder #(.STABLE_CYC(STABLE_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
        .digits(digits), .ind(ind), .frame_valid(frame_valid),
        .frame_err(frame_err), .stale(stale), .err_count(err_count)
    );

    typedef struct {
        logic [7:0]  s0, s1, s2, s3;
        logic [15:0] exp_digits;
        logic [3:0]  exp_ind;
        logic        exp_err;
        int          exp_nerr;
    } vec_t;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  ind;
        logic        err;
        logic [7:0]  errcnt;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     err_model = 0;
    vec_t   vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        frame_t f;
        if (rst_n && frame_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame actual digits=%h ind=%b required no frame", digits, ind);
            end else begin
                f = exp_q.pop_front();
                $display("frame digits=%h ind=%b err=%0d errcnt=%0d", digits, ind, frame_err, err_count);
                check("digits", 32'(digits), 32'(f.digits));
                check("ind", 32'(ind), 32'(f.ind));
                check("frame_err", 32'(frame_err), 32'(f.err));
                check("err_count", 32'(err_count), 32'(f.errcnt));
            end
        end
    end

    task automatic push_exp(input logic [15:0] d, input logic [3:0] i, input logic e, input int nerr);
        frame_t f;
        if (ERRCNT_ON) err_model = (err_model + nerr > 255) ? 255 : err_model + nerr;
        f.digits = d;
        f.ind    = i;
        f.err    = e;
        f.errcnt = 8'(err_model);
        exp_q.push_back(f);
    endtask

    // All drive tasks start and end on a falling edge; the value is held for n rising edges.
    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input int i, input logic [7:0] s, input int n);
        logic [3:0] a;
        a = ~(4'b0001 << i);
        drive(a, s, n);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_frame(input vec_t v);
        push_exp(v.exp_digits, v.exp_ind, v.exp_err, v.exp_nerr);
        digit(0, v.s0, 10);
        digit(1, v.s1, 10);
        digit(2, v.s2, 10);
        digit(3, v.s3, 10);
        drive(4'hF, 8'hFF, 2);
        wait_drain(20);
    endtask

    task automatic check_reset_outputs();
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_ind", 32'(ind), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_stale", 32'(stale), 32'h0);
        check("rst_err_count", 32'(err_count), 32'h0);
    endtask

    initial begin
        vt[0] = '{8'h81, 8'hCF, 8'h92, 8'h86, 16'h3210, 4'b0000, 1'b0, 0};
        vt[1] = '{8'h01, 8'h4F, 8'h12, 8'h06, 16'h3210, 4'b1111, 1'b0, 0};
        vt[2] = '{8'h01, 8'hFE, 8'h12, 8'h06, 16'h32F0, 4'b1101, 1'b0, 0};
        vt[3] = '{8'hAA, 8'h4F, 8'h12, 8'h06, 16'h321E, 4'b1110, 1'b1, 1};
        vt[4] = '{8'h24, 8'h20, 8'h0F, 8'h00, 16'h8765, 4'b1111, 1'b0, 0};
        vt[5] = '{8'h04, 8'h7F, 8'hFF, 8'h80, 16'h8AA9, 4'b0011, 1'b0, 0};
        vt[6] = '{8'h4C, 8'h7E, 8'h33, 8'hC1, 16'hEEF4, 4'b0111, 1'b1, 2};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Illegal an values then silence: no frame, stale rises exactly at TIMEOUT.
        drive(4'b1100, 8'h81, 20);
        drive(4'hF, 8'hFF, TIMEOUT - 21);
        check("stale_before_timeout", 32'(stale), 32'h0);
        @(negedge clk);
        check("stale_at_timeout", 32'(stale), 32'h1);

        for (int i = 0; i < 7; i++) begin
            run_frame(vt[i]);
            if (i == 0) check("stale_cleared", 32'(stale), 32'h0);
        end

        // Re-capture of digit 0 overwrites its slot without completing early.
        push_exp(16'h3215, 4'hF, 1'b0, 0);
        digit(0, 8'h01, 10);
        digit(1, 8'h4F, 10);
        digit(0, 8'h24, 10);
        digit(2, 8'h12, 10);
        digit(3, 8'h06, 10);
        drive(4'hF, 8'hFF, 2);
        wait_drain(20);

        // Illegal an mid-frame never fills the missing slot.
        digit(0, 8'h01, 10);
        digit(1, 8'h4F, 10);
        digit(2, 8'h12, 10);
        drive(4'b1100, 8'h86, 20);
        drive(4'b0011, 8'h86, 20);
        drive(4'hF, 8'hFF, 20);
        push_exp(16'h3210, 4'hF, 1'b0, 0);
        digit(3, 8'h06, 10);
        drive(4'hF, 8'hFF, 2);
        wait_drain(20);

        // Digit 2 held one cycle short of STABLE_CYC is dropped; held exactly STABLE_CYC it is taken.
        digit(0, 8'h01, 10);
        digit(1, 8'h4F, 10);
        digit(2, 8'h0F, STABLE_CYC - 1);
        drive(4'hF, 8'hFF, 5);
        digit(3, 8'h06, 10);
        drive(4'hF, 8'hFF, 10);
        push_exp(16'h3510, 4'hF, 1'b0, 0);
        digit(2, 8'h24, STABLE_CYC);
        drive(4'hF, 8'hFF, 10);
        wait_drain(20);

        // Reset after three captured digits discards them and clears all outputs.
        digit(0, 8'h01, 10);
        digit(1, 8'h4F, 10);
        digit(2, 8'h12, 10);
        drive(4'hF, 8'hFF, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        err_model = 0;
        digit(3, 8'h06, 10);
        drive(4'hF, 8'hFF, 10);
        run_frame(vt[3]);

        wait_drain(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
